// File: rtl/mult_pkg.sv
// Shared definitions for the multiplier / accumulator datapath.
//   DATA_W        - width of one product from the 8-bit multiplier stage
//   ACC_W_DEFAULT - default accumulator / output width
//   state_e       - accumulator control states (ACCUM, HOLD)
package mult_pkg;

  localparam int unsigned DATA_W        = 8;
  localparam int unsigned ACC_W_DEFAULT = 12;

  typedef enum logic {
    StAccum = 1'b0,
    StHold  = 1'b1
  } state_e;

endpackage

// File: rtl/sat_add.sv
// Adds one zero-extended product to the running sum.
// Build option: PRODUCT_ACCUMULATOR_SATURATE_EN
//   defined   - results above 2^Width-1 clamp to 2^Width-1
//   undefined - results wrap modulo 2^Width
// Ports:
//   a_i   - running sum (Width bits)
//   b_i   - unsigned product (DATA_W bits)
//   sum_o - a_i + b_i, saturated or wrapped (Width bits)
module sat_add
  import mult_pkg::*;
#(
  parameter int unsigned Width = ACC_W_DEFAULT
) (
  input  logic [Width-1:0]  a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [Width-1:0]  sum_o
);

  // One spare bit catches the carry out of the top.
  logic [Width:0] wide;

  assign wide = {1'b0, a_i} + {{(Width + 1 - DATA_W){1'b0}}, b_i};

`ifdef PRODUCT_ACCUMULATOR_SATURATE_EN
  // Once clamped the sum stays at max, since every later addend is non-negative.
  assign sum_o = wide[Width] ? {Width{1'b1}} : wide[Width-1:0];
`else
  assign sum_o = wide[Width-1:0];
`endif

endmodule

// File: rtl/product_accumulator.sv
// Sums ACC_LEN unsigned Q0.8 products and presents each completed sum on a
// valid/ready output. Input is stalled while a finished sum waits downstream.
// Build option: PRODUCT_ACCUMULATOR_SATURATE_EN (saturating instead of wrapping add).
// Ports:
//   clk       - clock, rising edge
//   rst       - asynchronous active-low reset
//   clr       - synchronous discard of the partial sum (ignored in HOLD)
//   in_valid  - in_data holds a product
//   in_data   - unsigned 8-bit product
//   in_ready  - product accepted this cycle when in_valid is high
//   out_valid - out_data holds a completed sum
//   out_data  - completed sum, ACC_W bits
//   out_ready - downstream takes out_data this cycle
module product_accumulator
  import mult_pkg::*;
#(
  parameter int unsigned ACC_LEN = 8,
  parameter int unsigned ACC_W   = ACC_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [ACC_W-1:0]  out_data,
  input  logic              out_ready
);

  localparam logic [7:0] LastCnt = 8'(ACC_LEN - 1);

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [ACC_W-1:0] out_data_q, out_data_d;
  logic [ACC_W-1:0] sum;

  sat_add #(
    .Width (ACC_W)
  ) u_sat_add (
    .a_i   (acc_q),
    .b_i   (in_data),
    .sum_o (sum)
  );

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    out_data_d = out_data_q;
    unique case (state_q)
      StAccum: begin
        if (clr) begin
          // clr wins over a simultaneous product, which is dropped.
          acc_d = '0;
          cnt_d = '0;
        end else if (in_valid) begin
          if (cnt_q == LastCnt) begin
            out_data_d = sum;
            acc_d      = '0;
            cnt_d      = '0;
            state_d    = StHold;
          end else begin
            acc_d = sum;
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      StHold: begin
        // No input is taken on the handshake edge; in_ready is low in HOLD.
        if (out_ready) begin
          state_d = StAccum;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StAccum;
      acc_q      <= '0;
      cnt_q      <= '0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      out_data_q <= out_data_d;
    end
  end

  assign in_ready  = (state_q == StAccum);
  assign out_valid = (state_q == StHold);
  assign out_data  = out_data_q;

endmodule

// File: doc/product_accumulator.md
PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

Interface
REQ-001 SHALL have parameter ACC_LEN, default 8, meaning the number of products summed per output (legal range 2..255).
REQ-002 SHALL have parameter ACC_W, default 12, meaning the accumulator and output width in bits (legal range 8..16).
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit, asynchronous active-low reset.
REQ-005 SHALL have port clr, input, 1 bit, synchronous discard of the partial sum.
REQ-006 SHALL have port in_valid, input, 1 bit, meaning in_data holds a product.
REQ-007 SHALL have port in_data, input, 8 bits, an unsigned Q0.8 product from the 8-bit multiplier stage.
REQ-008 SHALL have port in_ready, output, 1 bit, meaning the block accepts in_data this cycle.
REQ-009 SHALL have port out_valid, output, 1 bit, meaning out_data holds a completed sum.
REQ-010 SHALL have port out_data, output, ACC_W bits, the completed unsigned sum.
REQ-011 SHALL have port out_ready, input, 1 bit, meaning downstream takes out_data this cycle.

Function
REQ-012 SHALL implement states ACCUM and HOLD only; the reset state is ACCUM.
REQ-013 SHALL accept a product on a rising edge where in_valid and in_ready are both high.
REQ-014 SHALL drive in_ready high in ACCUM and low in HOLD.
REQ-015 SHALL, on each accepted product, zero-extend in_data to ACC_W and add it to acc, then increment the 8-bit counter cnt.
REQ-016 SHALL, when the accepted product is number ACC_LEN, register acc+in_data into out_data, clear acc and cnt, and enter HOLD with out_valid high from the next cycle (latency: 1 clock after the last accepted product).
REQ-017 SHALL keep out_valid high and out_data stable in HOLD until a rising edge with out_ready high, then return to ACCUM with out_valid low.
REQ-018 SHALL never accept input in the same cycle the output handshake completes.
REQ-019 SHALL, when clr is high in ACCUM, zero acc and cnt; clr takes priority over a simultaneous accepted product, which is discarded.
REQ-020 SHALL ignore clr in HOLD; a pending output is never dropped.
REQ-021 SHALL leave acc, cnt and state unchanged when in_valid is low in ACCUM.

Reset
REQ-022 SHALL, while rst is low, force state=ACCUM, acc=0, cnt=0, out_data=0 and out_valid=0 asynchronously, including mid-accumulation and while in HOLD.
REQ-023 SHALL present in_ready high on the first cycle after rst deasserts.

Configuration
REQ-024 SHALL use macro PRODUCT_ACCUMULATOR_SATURATE_EN: when defined, every addition that would exceed 2^ACC_W-1 clamps to 2^ACC_W-1 and stays clamped for the rest of the group; when undefined, additions wrap modulo 2^ACC_W.

Structure
REQ-025 SHALL import DATA_W=8, the default ACC_W and the ACCUM/HOLD state encoding from shared package mult_pkg.
REQ-026 SHALL place the add (saturating or wrapping under the macro) in one sub-module, sat_add.

Verification
REQ-027 SHALL verify: ACC_LEN=4, products 0x10,0x20,0x30,0x40 back-to-back, out_ready=1 -> out_valid for one cycle with out_data=0x0A0, one clock after the fourth accept.
REQ-028 SHALL verify: ACC_W=10, ACC_LEN=8, eight 0xFF products -> out_data=0x3FF with the macro defined, 0x3F8 without it.
REQ-029 SHALL verify: out_ready held low 3 cycles after a completed group -> out_valid and out_data stable and in_ready=0 for those cycles; release -> handshake completes, and in_ready=1 next cycle.
REQ-030 SHALL verify: ACC_LEN=4, accept 0x01,0x02, then clr with in_valid=1 and in_data=0x55, then 0x03 x4 -> out_data=0x00C.
REQ-031 SHALL verify: rst pulsed low after 3 of 4 accepts, and separately during HOLD -> all outputs 0 immediately; the next group of 0x01 x4 yields 0x004.
REQ-032 SHALL verify: in_valid toggled every other cycle with 0x80 x8, ACC_LEN=8 -> out_data=0x400, with no extra or missing accepts.
